// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: shared encodings for the multiply/divide unit.
//   - MDU_OP_* : operation codes shared with the decode stage.
//   - mdu_state_e : MDU control FSM states.
//   - mdu_is_mul / mdu_is_div : operation class helpers.
package mdu_unit_pkg;

  typedef logic [3:0] mdu_op_t;

  localparam mdu_op_t MDU_OP_NONE  = 4'd0;
  localparam mdu_op_t MDU_OP_DIV   = 4'd1;
  localparam mdu_op_t MDU_OP_DIVU  = 4'd2;
  localparam mdu_op_t MDU_OP_MUL   = 4'd3;
  localparam mdu_op_t MDU_OP_MULT  = 4'd4;
  localparam mdu_op_t MDU_OP_MULTU = 4'd5;
  localparam mdu_op_t MDU_OP_MFHI  = 4'd6;
  localparam mdu_op_t MDU_OP_MFLO  = 4'd7;
  localparam mdu_op_t MDU_OP_MTHI  = 4'd8;
  localparam mdu_op_t MDU_OP_MTLO  = 4'd9;

  // One quotient bit is produced per divider step.
  localparam int MDU_DIV_STEPS = 32;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_MUL  = 2'd1,
    MDU_ST_DIV  = 2'd2,
    MDU_ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic mdu_is_mul(input mdu_op_t op);
    return (op == MDU_OP_MUL) || (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
  endfunction

  function automatic logic mdu_is_div(input mdu_op_t op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// mdu_unit_if: EX-stage <-> MDU bundle.
//   mdu_op_i/mdu_valid_i/flush_i/rs_i/rt_i : request from the pipeline
//   mdu_busy_o   : stall request back to the pipeline
//   mdu_result_o : GPR write data (MFHI/MFLO/MUL)
//   hi_o/lo_o    : architectural HI/LO for debug/trace
// master = pipeline side, slave = MDU side.
interface mdu_unit_if;
  import mdu_unit_pkg::*;

  mdu_op_t     mdu_op_i;
  logic        mdu_valid_i;
  logic        flush_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        mdu_busy_o;
  logic [31:0] mdu_result_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output mdu_op_i, mdu_valid_i, flush_i, rs_i, rt_i,
    input  mdu_busy_o, mdu_result_o, hi_o, lo_o
  );

  modport slave (
    input  mdu_op_i, mdu_valid_i, flush_i, rs_i, rt_i,
    output mdu_busy_o, mdu_result_o, hi_o, lo_o
  );

endinterface

// File: rtl/mdu_divider.sv
// mdu_divider: 32-step radix-2 restoring divider.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : load operands (one cycle pulse)
//   abort               : cancel an operation in flight (wins over start)
//   signed_i            : signed (DIV) vs unsigned (DIVU) operands
//   dividend, divisor   : operands, sampled on start
//   busy                : a division is in progress
//   done                : final step cycle; quotient/remainder valid now
//   quotient, remainder : sign-corrected results, valid while done=1
// Divide by zero yields quotient all-ones and remainder = raw dividend;
// 0x8000_0000 / -1 (signed) yields quotient 0x8000_0000, remainder 0.
module mdu_divider
  import mdu_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        signed_i,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] raw_q, raw_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;

  logic        a_neg, b_neg, last, fits;
  logic [31:0] abs_a, abs_b, rem_step, quo_step;
  logic [32:0] shifted, diff;

  assign a_neg = signed_i & dividend[31];
  assign b_neg = signed_i & divisor[31];
  assign abs_a = a_neg ? -dividend : dividend;
  assign abs_b = b_neg ? -divisor : divisor;

  // Restoring step: shift the next dividend bit into the partial remainder
  // and keep the subtraction only when it does not go negative.
  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign fits     = ~diff[32];
  assign rem_step = fits ? diff[31:0] : shifted[31:0];
  assign quo_step = {quo_q[30:0], fits};
  assign last     = (cnt_q == 5'(MDU_DIV_STEPS - 1));

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = abs_a;
      dvs_d   = abs_b;
      raw_d   = dividend;
      q_neg_d = signed_i & (dividend[31] ^ divisor[31]);
      r_neg_d = a_neg;
      zero_d  = (divisor == 32'd0);
      ovf_d   = signed_i && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + 5'd1;
      if (last) busy_d = 1'b0;
    end
  end

  // Results are presented during the final step, with sign correction and
  // the special-case overrides folded in.
  always_comb begin
    if (zero_q)       quotient = 32'hFFFF_FFFF;
    else if (ovf_q)   quotient = 32'h8000_0000;
    else if (q_neg_q) quotient = -quo_step;
    else              quotient = quo_step;

    if (zero_q)       remainder = raw_q;
    else if (ovf_q)   remainder = 32'd0;
    else if (r_neg_q) remainder = -rem_step;
    else              remainder = rem_step;
  end

  assign busy = busy_q;
  assign done = busy_q & last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: EX-stage multiply/divide unit owning HI/LO.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : mdu_unit_if.slave (op/valid/flush/rs/rt in; busy/result/hi/lo out)
// Multiplies run through a MUL_LATENCY-deep (1..4) product pipe; divides use
// the iterative mdu_divider. Busy stalls the pipeline so the issuing
// instruction stays in EX until the one-cycle DONE state.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  mdu_unit_if.slave  bus
);

  mdu_state_e  state_q, state_d;
  mdu_op_t     op_q, op_d;
  logic [2:0]  mul_cnt_q, mul_cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] mul_pipe_q [MUL_LATENCY];
  logic [63:0] mul_pipe_d [MUL_LATENCY];

  logic               mul_signed;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] mul_product;
  logic               issue_ok, issue_mul, issue_div, mul_last, mul_shift;
  logic               div_busy, div_done;
  logic [31:0]        div_quotient, div_remainder;

  // 33-bit operands let one signed multiplier serve MULT and MULTU.
  assign mul_signed  = (bus.mdu_op_i != MDU_OP_MULTU);
  assign mul_a       = {mul_signed & bus.rs_i[31], bus.rs_i};
  assign mul_b       = {mul_signed & bus.rt_i[31], bus.rt_i};
  assign mul_product = 64'(mul_a) * 64'(mul_b);

  assign issue_ok  = (state_q == MDU_ST_IDLE) && bus.mdu_valid_i && !bus.flush_i;
  assign issue_mul = issue_ok && mdu_is_mul(bus.mdu_op_i);
  assign issue_div = issue_ok && mdu_is_div(bus.mdu_op_i);
  assign mul_last  = (state_q == MDU_ST_MUL) && (mul_cnt_q == 3'(MUL_LATENCY - 1));
  // The pipe freezes in the last MUL cycle so the product is still held
  // in the final stage during DONE.
  assign mul_shift = issue_mul || ((state_q == MDU_ST_MUL) && !mul_last);

  mdu_divider u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (issue_div),
    .abort     (bus.flush_i),
    .signed_i  (bus.mdu_op_i == MDU_OP_DIV),
    .dividend  (bus.rs_i),
    .divisor   (bus.rt_i),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mul_cnt_d  = mul_cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mul_pipe_d = mul_pipe_q;

    if (mul_shift) begin
      mul_pipe_d[0] = mul_product;
      for (int i = 1; i < MUL_LATENCY; i++) mul_pipe_d[i] = mul_pipe_q[i-1];
    end

    if (bus.flush_i) begin
      state_d = MDU_ST_IDLE;
    end else begin
      case (state_q)
        MDU_ST_IDLE: begin
          mul_cnt_d = '0;
          if (issue_mul) begin
            state_d = MDU_ST_MUL;
            op_d    = bus.mdu_op_i;
          end else if (issue_div) begin
            state_d = MDU_ST_DIV;
            op_d    = bus.mdu_op_i;
          end else if (bus.mdu_valid_i && (bus.mdu_op_i == MDU_OP_MTHI)) begin
            hi_d = bus.rs_i;
          end else if (bus.mdu_valid_i && (bus.mdu_op_i == MDU_OP_MTLO)) begin
            lo_d = bus.rs_i;
          end
        end
        MDU_ST_MUL: begin
          mul_cnt_d = mul_cnt_q + 3'd1;
          if (mul_last) begin
            state_d = MDU_ST_DONE;
            if (op_q != MDU_OP_MUL) {hi_d, lo_d} = mul_pipe_q[MUL_LATENCY-1];
          end
        end
        MDU_ST_DIV: begin
          if (div_done) begin
            state_d = MDU_ST_DONE;
            hi_d    = div_remainder;
            lo_d    = div_quotient;
          end else if (!div_busy) begin
            state_d = MDU_ST_IDLE;
          end
        end
        MDU_ST_DONE: state_d = MDU_ST_IDLE;
        default:     state_d = MDU_ST_IDLE;
      endcase
    end
  end

  // Outputs: a flush or reset silences busy and any pending result at once.
  always_comb begin
    bus.mdu_busy_o   = 1'b0;
    bus.mdu_result_o = '0;
    if (rst_n && !bus.flush_i) begin
      case (state_q)
        MDU_ST_IDLE: begin
          bus.mdu_busy_o = bus.mdu_valid_i &&
                           (mdu_is_mul(bus.mdu_op_i) || mdu_is_div(bus.mdu_op_i));
          if (bus.mdu_valid_i && (bus.mdu_op_i == MDU_OP_MFHI)) bus.mdu_result_o = hi_q;
          if (bus.mdu_valid_i && (bus.mdu_op_i == MDU_OP_MFLO)) bus.mdu_result_o = lo_q;
        end
        MDU_ST_MUL, MDU_ST_DIV: bus.mdu_busy_o = 1'b1;
        MDU_ST_DONE: begin
          if (op_q == MDU_OP_MUL) bus.mdu_result_o = mul_pipe_q[MUL_LATENCY-1][31:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MDU_ST_IDLE;
      op_q      <= MDU_OP_NONE;
      mul_cnt_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) mul_pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mul_cnt_q  <= mul_cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mul_pipe_q <= mul_pipe_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed, table-driven bench for mdu_unit (MUL_LATENCY = 2),
// plus hand-written flush and mid-operation reset sequences.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mdu_unit_if bus ();

  mdu_unit #(.MUL_LATENCY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    mdu_op_t     op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          cycles;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one instruction, count busy cycles, check the result in the
  // first non-busy cycle, then retire it and check HI/LO.
  task automatic apply(input string tag, input mdu_op_t op, input logic [31:0] rs,
                       input logic [31:0] rt, input int exp_cycles,
                       input logic [31:0] exp_res, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
    int cycles;
    @(negedge clk);
    bus.mdu_op_i    = op;
    bus.mdu_valid_i = 1'b1;
    bus.rs_i        = rs;
    bus.rt_i        = rt;
    #1;
    cycles = 0;
    while (bus.mdu_busy_o && cycles < 100) begin
      cycles++;
      @(negedge clk);
      #1;
    end
    check({tag, "_busy_cycles"}, 32'(cycles), 32'(exp_cycles));
    check({tag, "_result"}, bus.mdu_result_o, exp_res);
    @(negedge clk);
    bus.mdu_valid_i = 1'b0;
    bus.mdu_op_i    = MDU_OP_NONE;
    #1;
    check({tag, "_hi"}, bus.hi_o, exp_hi);
    check({tag, "_lo"}, bus.lo_o, exp_lo);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{MDU_OP_MTHI,  32'h1234_5678, 32'h0,          0,  32'h0,          32'h1234_5678, 32'h0};
    vecs[1]  = '{MDU_OP_MTLO,  32'hDEAD_BEEF, 32'h0,          0,  32'h0,          32'h1234_5678, 32'hDEAD_BEEF};
    vecs[2]  = '{MDU_OP_MFHI,  32'h0,         32'h0,          0,  32'h1234_5678,  32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3]  = '{MDU_OP_MFLO,  32'h0,         32'h0,          0,  32'hDEAD_BEEF,  32'h1234_5678, 32'hDEAD_BEEF};
    vecs[4]  = '{MDU_OP_MULT,  32'hFFFF_FFFD, 32'd5,          3,  32'h0,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[5]  = '{MDU_OP_MFLO,  32'h0,         32'h0,          0,  32'hFFFF_FFF1,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[6]  = '{MDU_OP_MUL,   32'h0001_0000, 32'h0001_0000,  3,  32'h0,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[7]  = '{MDU_OP_MUL,   32'd7,         32'hFFFF_FFFA,  3,  32'hFFFF_FFD6,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[8]  = '{MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  3,  32'h0,          32'hFFFF_FFFE, 32'h0000_0001};
    vecs[9]  = '{MDU_OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  3,  32'h0,          32'h0,         32'h0000_0001};
    vecs[10] = '{MDU_OP_MULT,  32'h8000_0000, 32'h8000_0000,  3,  32'h0,          32'h4000_0000, 32'h0};
    vecs[11] = '{MDU_OP_DIV,   32'hFFFF_FFF9, 32'd2,          33, 32'h0,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[12] = '{MDU_OP_DIVU,  32'd100,       32'd0,          33, 32'h0,          32'd100,       32'hFFFF_FFFF};
    vecs[13] = '{MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  33, 32'h0,          32'h0,         32'h8000_0000};
    vecs[14] = '{MDU_OP_DIV,   32'hFFFF_FFF9, 32'd0,          33, 32'h0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[15] = '{MDU_OP_DIVU,  32'hFFFF_FFFF, 32'd2,          33, 32'h0,          32'd1,         32'h7FFF_FFFF};
    vecs[16] = '{MDU_OP_DIV,   32'd7,         32'hFFFF_FFFE,  33, 32'h0,          32'd1,         32'hFFFF_FFFD};
    vecs[17] = '{MDU_OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE,  33, 32'h0,          32'hFFFF_FFFF, 32'd3};
    vecs[18] = '{MDU_OP_MFHI,  32'h0,         32'h0,          0,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd3};
    vecs[19] = '{MDU_OP_DIVU,  32'd7,         32'd9,          33, 32'h0,          32'd7,         32'd0};

    // Reset state, with a divide request pending to show busy stays low.
    rst_n           = 1'b0;
    bus.flush_i     = 1'b0;
    bus.mdu_valid_i = 1'b1;
    bus.mdu_op_i    = MDU_OP_DIV;
    bus.rs_i        = 32'd5;
    bus.rt_i        = 32'd1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", {31'd0, bus.mdu_busy_o}, 32'd0);
    check("reset_result", bus.mdu_result_o, 32'd0);
    check("reset_hi", bus.hi_o, 32'd0);
    check("reset_lo", bus.lo_o, 32'd0);
    @(negedge clk);
    bus.mdu_valid_i = 1'b0;
    bus.mdu_op_i    = MDU_OP_NONE;
    rst_n           = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply($sformatf("v%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
            vecs[i].cycles, vecs[i].res, vecs[i].hi, vecs[i].lo);
    end

    // Flush in cycle 10 of a divide: busy drops at once, HI/LO untouched.
    apply("mthi_a5", MDU_OP_MTHI, 32'hA5A5_A5A5, 32'd0, 0, 32'd0, 32'hA5A5_A5A5, 32'd0);
    @(negedge clk);
    bus.mdu_op_i    = MDU_OP_DIV;
    bus.mdu_valid_i = 1'b1;
    bus.rs_i        = 32'hFFFF_FFF9;
    bus.rt_i        = 32'd2;
    repeat (9) @(negedge clk);
    #1;
    check("flush_pre_busy", {31'd0, bus.mdu_busy_o}, 32'd1);
    bus.flush_i = 1'b1;
    #1;
    check("flush_busy_now", {31'd0, bus.mdu_busy_o}, 32'd0);
    @(negedge clk);
    bus.flush_i     = 1'b0;
    bus.mdu_valid_i = 1'b0;
    bus.mdu_op_i    = MDU_OP_NONE;
    #1;
    check("flush_busy_after", {31'd0, bus.mdu_busy_o}, 32'd0);
    check("flush_hi", bus.hi_o, 32'hA5A5_A5A5);
    apply("flush_mfhi", MDU_OP_MFHI, 32'd0, 32'd0, 0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0);
    repeat (40) @(negedge clk);
    #1;
    check("flush_late_hi", bus.hi_o, 32'hA5A5_A5A5);
    check("flush_late_lo", bus.lo_o, 32'd0);

    // Reset in cycle 5 of a divide, then a fresh DIVU.
    apply("mtlo_5a", MDU_OP_MTLO, 32'h5A5A_5A5A, 32'd0, 0, 32'd0, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    @(negedge clk);
    bus.mdu_op_i    = MDU_OP_DIV;
    bus.mdu_valid_i = 1'b1;
    bus.rs_i        = 32'd100;
    bus.rt_i        = 32'd7;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, bus.mdu_busy_o}, 32'd0);
    check("rst_mid_hi", bus.hi_o, 32'd0);
    check("rst_mid_lo", bus.lo_o, 32'd0);
    check("rst_mid_result", bus.mdu_result_o, 32'd0);
    @(negedge clk);
    bus.mdu_valid_i = 1'b0;
    bus.mdu_op_i    = MDU_OP_NONE;
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst_divu", MDU_OP_DIVU, 32'd9, 32'd4, 33, 32'd0, 32'd1, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
